// File: rtl/fetch_ctrl.sv
// PC sequencer and single-outstanding instruction fetch with valid/ready handoff to decode.
// Optional misaligned-redirect trap to TRAP_VEC with sticky fetch_err: define FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] fetch_count,
  output logic        fetch_err
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic [31:0] drain_tgt, drain_tgt_n;
  logic [31:0] instr_out_n, instr_pc_n, fetch_count_n;
  logic        imem_req_n, instr_valid_n;
  logic        misalign;
  logic [31:0] redirect_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = |redirect_pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  // Low address bits are dropped so the PC can never become misaligned.
  assign redirect_tgt = misalign ? TRAP_VEC : (redirect_pc & 32'hFFFF_FFFC);

  // The in-flight address is pc itself: pc only moves once the request retires.
  assign imem_addr = pc;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_VEC;
      drain_tgt   <= 32'h0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= 32'h0;
      instr_pc    <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      drain_tgt   <= drain_tgt_n;
      imem_req    <= imem_req_n;
      instr_valid <= instr_valid_n;
      instr_out   <= instr_out_n;
      instr_pc    <= instr_pc_n;
      fetch_count <= fetch_count_n;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)
      fetch_err <= 1'b0;
    else if (redirect && misalign)
      fetch_err <= 1'b1;
  end
`else
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default here first so no path leaves one unassigned (no latches).
    state_n       = state;
    pc_n          = pc;
    drain_tgt_n   = drain_tgt;
    imem_req_n    = imem_req;
    instr_valid_n = instr_valid;
    instr_out_n   = instr_out;
    instr_pc_n    = instr_pc;
    fetch_count_n = fetch_count;

    unique case (state)
      FETCH: begin
        imem_req_n = 1'b1;
        if (imem_req && imem_ack) begin
          if (redirect) begin
            pc_n = redirect_tgt;
          end else begin
            instr_out_n   = imem_rdata;
            instr_pc_n    = pc;
            instr_valid_n = 1'b1;
            pc_n          = pc + 32'd4;
            imem_req_n    = 1'b0;
            state_n       = HOLD;
          end
        end else if (redirect) begin
          if (imem_req) begin
            drain_tgt_n = redirect_tgt;
            state_n     = DRAIN;
          end else begin
            // Nothing outstanding yet, so the new target can be taken directly.
            pc_n = redirect_tgt;
          end
        end
      end

      DRAIN: begin
        imem_req_n = 1'b1;
        if (imem_ack) begin
          pc_n    = redirect ? redirect_tgt : drain_tgt;
          state_n = FETCH;
        end else if (redirect) begin
          drain_tgt_n = redirect_tgt;
        end
      end

      HOLD: begin
        imem_req_n = 1'b0;
        if (instr_ready)
          fetch_count_n = fetch_count + 32'd1;
        if (instr_ready || redirect) begin
          instr_valid_n = 1'b0;
          imem_req_n    = 1'b1;
          state_n       = FETCH;
          if (redirect)
            pc_n = redirect_tgt;
        end
      end

      default: begin
        state_n = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a latency-programmable memory responder plus one task per scenario.
// Inputs are driven and outputs sampled on the falling edge; the memory updates 1ns after the rising edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] fetch_count;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  int   mem_lat   = 1;
  int   mem_cnt   = 0;
  bit   tag_data  = 1'b0;
  logic ack_model = 1'b0;
  logic ack_extra = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .fetch_count (fetch_count),
    .fetch_err   (fetch_err)
  );

  // Memory acks after the request has been seen for mem_lat cycles; tagged data encodes the address.
  assign imem_ack   = ack_model | ack_extra;
  assign imem_rdata = tag_data ? (imem_addr ^ 32'h0000_0013) : 32'h0000_0013;

  always @(posedge clk) begin
    #1;
    if (reset || !imem_req) begin
      ack_model = 1'b0;
      mem_cnt   = 0;
    end else begin
      if (ack_model) begin
        ack_model = 1'b0;
        mem_cnt   = 0;
      end
      if (mem_cnt >= mem_lat) ack_model = 1'b1;
      else mem_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    ack_extra   = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    mem_lat = 1; tag_data = 1'b0;
    do_reset();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out got %h want 0", instr_out); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got %h want 0", instr_pc); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", fetch_err); end
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_stream();
    int n_valid = 0;
    mem_lat = 1; tag_data = 1'b0;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      if (instr_valid === 1'b1) begin
        checks++; if (instr_pc !== 32'(n_valid * 4)) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", n_valid, instr_pc, n_valid * 4); end
        checks++; if (instr_out !== 32'h13) begin errors++; $display("FAIL stream_data[%0d] got %h want 00000013", n_valid, instr_out); end
        n_valid++;
      end
    end
    checks++; if (n_valid != 4) begin errors++; $display("FAIL stream_valid_cycles got %0d want 4", n_valid); end
    checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL stream_count got %0d want 4", fetch_count); end
    instr_ready = 1'b0;
  endtask

  task automatic test_hold();
    bit ok;
    mem_lat = 1; tag_data = 1'b1;
    do_reset();
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got no valid want valid"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== 32'h13 || instr_pc !== 32'h0 || imem_req !== 1'b0 || fetch_count !== 32'h0) begin
        errors++;
        $display("FAIL hold_stable[%0d] got v=%b out=%h pc=%h req=%b cnt=%0d want v=1 out=00000013 pc=0 req=0 cnt=0",
                 i, instr_valid, instr_out, instr_pc, imem_req, fetch_count);
      end
      if (i < 4) step();
    end
    instr_ready = 1'b1;
    step();
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL hold_release_count got %0d want 1", fetch_count); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %b want 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL hold_next_fetch got req=%b addr=%h want req=1 addr=4", imem_req, imem_addr); end
    instr_ready = 1'b0;
  endtask

  task automatic test_drain();
    bit ok;
    mem_lat = 3; tag_data = 1'b1;
    do_reset();
    instr_ready = 1'b1;
    step();
    step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL drain_hold1 got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL drain_hold2 got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    step();
    checks++; if (imem_addr !== 32'h200 || instr_valid !== 1'b0) begin errors++; $display("FAIL drain_resume got addr=%h v=%b want addr=200 v=0", imem_addr, instr_valid); end
    wait_valid(ok);
    checks++; if (!ok || instr_pc !== 32'h200) begin errors++; $display("FAIL drain_instr_pc got %h want 00000200", instr_pc); end
    checks++; if (instr_out !== 32'h213) begin errors++; $display("FAIL drain_instr_out got %h want 00000213", instr_out); end
    instr_ready = 1'b0;
  endtask

  task automatic test_two_redirects();
    bit ok;
    mem_lat = 4; tag_data = 1'b1;
    do_reset();
    instr_ready = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL two_redir_held got %h want 0", imem_addr); end
    step();
    step();
    checks++; if (imem_addr !== 32'h400 || pc !== 32'h400) begin errors++; $display("FAIL two_redir_resume got addr=%h pc=%h want 400", imem_addr, pc); end
    wait_valid(ok);
    checks++; if (!ok || instr_pc !== 32'h400) begin errors++; $display("FAIL two_redir_instr_pc got %h want 00000400", instr_pc); end
    instr_ready = 1'b0;
  endtask

  task automatic test_ack_redirect();
    bit ok;
    mem_lat = 1; tag_data = 1'b1;
    do_reset();
    instr_ready = 1'b1;
    step();
    step();
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin errors++; $display("FAIL ack_redir_discard got v=%b req=%b addr=%h want v=0 req=1 addr=80", instr_valid, imem_req, imem_addr); end
    wait_valid(ok);
    checks++; if (!ok || instr_pc !== 32'h80) begin errors++; $display("FAIL ack_redir_instr_pc got %h want 00000080", instr_pc); end
    instr_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    mem_lat = 1; tag_data = 1'b1;
    do_reset();
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got no valid want valid"); end
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL b2b_count got %0d want 1", fetch_count); end
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL b2b_next got v=%b req=%b addr=%h want v=0 req=1 addr=40", instr_valid, imem_req, imem_addr); end
    wait_valid(ok);
    checks++; if (!ok || instr_pc !== 32'h40) begin errors++; $display("FAIL b2b_instr_pc got %h want 00000040", instr_pc); end
    instr_ready = 1'b0;
  endtask

  task automatic test_pc_wrap();
    bit ok;
    mem_lat = 1; tag_data = 1'b1;
    do_reset();
    wait_valid(ok);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0; instr_ready = 1'b1;
    wait_valid(ok);
    checks++; if (!ok || instr_pc !== 32'hFFFF_FFFC || instr_out !== 32'hFFFF_FFEF) begin errors++; $display("FAIL wrap_top got pc=%h out=%h want pc=fffffffc out=ffffffef", instr_pc, instr_out); end
    wait_valid(ok);
    checks++; if (!ok || instr_pc !== 32'h0) begin errors++; $display("FAIL wrap_next got %h want 00000000", instr_pc); end
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_in_drain();
    bit ok;
    mem_lat = 5; tag_data = 1'b1;
    do_reset();
    step();
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0; reset = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rst_drain got req=%b pc=%h v=%b want req=0 pc=0 v=0", imem_req, pc, instr_valid); end
    reset = 1'b0; ack_extra = 1'b1;
    step();
    ack_extra = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rst_late_ack got req=%b addr=%h v=%b want req=1 addr=0 v=0", imem_req, imem_addr, instr_valid); end
    mem_lat = 1; instr_ready = 1'b1;
    wait_valid(ok);
    checks++; if (!ok || instr_pc !== 32'h0) begin errors++; $display("FAIL rst_drain_instr_pc got %h want 00000000", instr_pc); end
    instr_ready = 1'b0;
  endtask

  task automatic test_misalign();
    bit ok;
    logic [31:0] exp_pc;
    logic        exp_err;
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_pc = 32'h100; exp_err = 1'b1;
`else
    exp_pc = 32'h200; exp_err = 1'b0;
`endif
    mem_lat = 1; tag_data = 1'b1;
    do_reset();
    wait_valid(ok);
    redirect = 1'b1; redirect_pc = 32'h0000_0202;
    step();
    redirect = 1'b0;
    checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL misalign_addr got %h want %h", imem_addr, exp_pc); end
    checks++; if (fetch_err !== exp_err) begin errors++; $display("FAIL misalign_err got %b want %b", fetch_err, exp_err); end
    instr_ready = 1'b1;
    wait_valid(ok);
    checks++; if (!ok || instr_pc !== exp_pc) begin errors++; $display("FAIL misalign_instr_pc got %h want %h", instr_pc, exp_pc); end
    checks++; if (fetch_err !== exp_err) begin errors++; $display("FAIL misalign_err_sticky got %b want %b", fetch_err, exp_err); end
    instr_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_hold();
    test_drain();
    test_two_redirects();
    test_ack_redirect();
    test_back_to_back();
    test_pc_wrap();
    test_reset_in_drain();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter and instruction-memory fetch for the RISC-V core.
- Owns the PC register and its +4 increment.
- Issues one request at a time to instruction memory over a variable-latency req/ack handshake.
- Presents fetched instructions to decode over a valid/ready handshake, and applies branch/jump redirects, including while a fetch is in flight.

Parameters:
- RESET_VEC, 32'h0000_0000: PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100: fetch target after a misaligned redirect (optional feature only).

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- imem_req, output, 1: fetch request to instruction memory.
- imem_addr, output, 32: fetch address; stable while imem_req=1 and imem_ack=0.
- imem_ack, input, 1: memory has returned imem_rdata this cycle; ignored when imem_req=0.
- imem_rdata, input, 32: instruction word, valid when imem_ack=1.
- instr_valid, output, 1: instr_out/instr_pc are valid for decode.
- instr_ready, input, 1: decode accepts the instruction this cycle.
- instr_out, output, 32: fetched instruction.
- instr_pc, output, 32: address of instr_out.
- redirect, input, 1: taken branch/jump/flush this cycle.
- redirect_pc, input, 32: new fetch target when redirect=1.
- pc, output, 32: current fetch PC (next address to be, or being, fetched).
- fetch_count, output, 32: number of instructions accepted by decode.
- fetch_err, output, 1: misaligned redirect flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values, applied when reset=1 at a posedge: pc=RESET_VEC, imem_req=0, instr_valid=0, instr_out=0, instr_pc=0, fetch_count=0, fetch_err=0, state=FETCH, drain target cleared.
- Reset mid-transaction drops the request and any pending target. A late imem_ack arriving after reset, while imem_req=0, is ignored.
- First cycle after reset deasserts: imem_req=1, imem_addr=RESET_VEC.
- States: FETCH, HOLD, DRAIN.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - ack with no redirect: instr_out<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go to HOLD.
  - ack with redirect in the same cycle: discard data, pc<=redirect_pc, stay in FETCH. New address appears next cycle.
  - redirect without ack: latch redirect_pc as drain target, go to DRAIN. imem_addr keeps the old pc.
- DRAIN:
  - imem_req=1, imem_addr=old pc.
  - Further redirects overwrite the target; the latest one wins.
  - On ack: discard data, pc<=target, go to FETCH.
  - Ack and redirect in the same cycle: the new redirect_pc is used as the target.
- HOLD:
  - imem_req=0; instr_valid=1 and instr_out/instr_pc are held stable.
  - instr_ready=1: instr_valid<=0, fetch_count<=fetch_count+1, go to FETCH (next request next cycle).
  - redirect=1: instr_valid<=0, pc<=redirect_pc, go to FETCH.
  - redirect and instr_ready in the same cycle: the transfer counts (fetch_count increments) and the redirect is taken.
- Throughput: at best one instruction every 3 cycles (request, ack, handoff) with a zero-wait memory.
- Arithmetic:
  - pc+4 wraps modulo 2^32; pc=32'hFFFF_FFFC advances to 32'h0000_0000.
  - fetch_count wraps from 32'hFFFF_FFFF to 0.
- No combinational path from imem_ack or instr_ready to imem_req.
- Every output is registered except imem_addr, which equals pc in FETCH and the held address in DRAIN.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_err<=1 (sticky until reset).
  - The target used is TRAP_VEC instead of redirect_pc, in every state, including the DRAIN target latch.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 before use.
  - fetch_err is constant 0.

Test Plan:
- Zero-wait memory returns 32'h0000_0013 for every address, instr_ready=1 constantly, run 12 cycles after reset -> instr_pc sequence 0,4,8,12; fetch_count=4; instr_valid high one cycle per instruction.
- instr_ready held low 5 cycles in HOLD -> instr_valid, instr_out and instr_pc stable; no imem_req; fetch_count unchanged; releasing it increments fetch_count by 1.
- Memory acks after 3 cycles; redirect to 32'h0000_0200 one cycle after the request -> imem_addr held at 0 until ack; data discarded; next imem_addr=32'h200; instr_pc of the next valid=32'h200.
- Two redirects during DRAIN (32'h300, then 32'h400) -> fetch resumes at 32'h400 only.
- Redirect to 32'h40 in HOLD with instr_ready=1 in the same cycle -> fetch_count increments; next fetch address 32'h40.
- pc forced to 32'hFFFF_FFFC via redirect -> next instr_pc after it is 0.
- Reset asserted during DRAIN -> imem_req=0 next cycle, pc=RESET_VEC.
- Macro defined: redirect to 32'h0000_0202 -> fetch_err=1, next fetch at 32'h100.
- Macro undefined: redirect to 32'h0000_0202 -> next fetch at 32'h200.
